// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types and sizing for the register-file write port arbiter
package cv32e40p_pkg;
   localparam int RF_ADDR_WIDTH = 6;
   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_WBUF_DEPTH = 2;
   typedef struct packed {logic live; logic [5:0] waddr; logic [31:0] wdata;} rf_wreq_t;
endpackage

// File: rtl/cv32e40p_rf_wport_arbiter_if.sv
// cv32e40p_rf_wport_arbiter_if: ALU, LSU, register-file and bypass signals of the write port arbiter
interface cv32e40p_rf_wport_arbiter_if
   import cv32e40p_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int BUF_DEPTH  = RF_WBUF_DEPTH
) ();
   localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);
   logic                  alu_we_i;
   logic [ADDR_WIDTH-1:0] alu_waddr_i;
   logic [DATA_WIDTH-1:0] alu_wdata_i;
   logic                  wb_we_i;
   logic [ADDR_WIDTH-1:0] wb_waddr_i;
   logic [DATA_WIDTH-1:0] wb_wdata_i;
   logic                  wb_ready_o;
   logic                  rf_we_o;
   logic [ADDR_WIDTH-1:0] rf_waddr_o;
   logic [DATA_WIDTH-1:0] rf_wdata_o;
   logic [ADDR_WIDTH-1:0] raddr_a_i;
   logic [ADDR_WIDTH-1:0] raddr_b_i;
   logic                  fwd_hit_a_o;
   logic                  fwd_hit_b_o;
   logic [DATA_WIDTH-1:0] fwd_data_a_o;
   logic [DATA_WIDTH-1:0] fwd_data_b_o;
   logic [CNT_WIDTH-1:0]  pend_cnt_o;
   modport master (
      output alu_we_i, alu_waddr_i, alu_wdata_i, wb_we_i, wb_waddr_i, wb_wdata_i, raddr_a_i, raddr_b_i,
      input  wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o, pend_cnt_o
   );
   modport slave (
      input  alu_we_i, alu_waddr_i, alu_wdata_i, wb_we_i, wb_waddr_i, wb_wdata_i, raddr_a_i, raddr_b_i,
      output wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o, pend_cnt_o
   );
endinterface

// File: rtl/cv32e40p_rf_wbuf.sv
// cv32e40p_rf_wbuf: ordered park buffer for LSU writes with kill and youngest-match lookup
module cv32e40p_rf_wbuf
   import cv32e40p_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int DEPTH      = RF_WBUF_DEPTH,
   localparam int CW        = $clog2(DEPTH + 1),
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  push_live,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  kill,
   input  logic [ADDR_WIDTH-1:0] kill_addr,
   output logic                  head_live,
   output logic [ADDR_WIDTH-1:0] head_addr,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [CW-1:0]         cnt,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic                  hit_a,
   output logic                  hit_b,
   output logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] data_b
);
   logic                  live_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]         hd_q, tl_q;
   logic [CW-1:0]         cnt_q;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign head_live = live_q[hd_q];
   assign head_addr = addr_q[hd_q];
   assign head_data = data_q[hd_q];
   assign cnt       = cnt_q;

   // kill matching entries on an ALU write, then enqueue at tail and advance head on pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
         for (int k = 0; k < DEPTH; k++) live_q[k] <= 1'b0;
      end else begin
         for (int k = 0; k < DEPTH; k++) if (kill && addr_q[k] == kill_addr) live_q[k] <= 1'b0;
         if (push) begin
            live_q[tl_q] <= push_live;
            addr_q[tl_q] <= push_addr;
            data_q[tl_q] <= push_data;
            tl_q         <= nxt(tl_q);
         end
         if (pop) hd_q <= nxt(hd_q);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   // walk occupied entries head to tail so the youngest live match wins
   always_comb begin
      logic [PW-1:0] j;
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      data_a = '0;
      data_b = '0;
      j      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         j = PW'((int'(hd_q) + i) % DEPTH);
         if (i < int'(cnt_q) && live_q[j] && raddr_a != '0 && addr_q[j] == raddr_a) begin
            hit_a  = 1'b1;
            data_a = data_q[j];
         end
         if (i < int'(cnt_q) && live_q[j] && raddr_b != '0 && addr_q[j] == raddr_b) begin
            hit_b  = 1'b1;
            data_b = data_q[j];
         end
      end
   end
endmodule

// File: rtl/cv32e40p_rf_wport_arbiter.sv
// cv32e40p_rf_wport_arbiter: shares the register-file write port between ALU and LSU, ALU first
module cv32e40p_rf_wport_arbiter
   import cv32e40p_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int BUF_DEPTH  = RF_WBUF_DEPTH
) (
   input logic                          clk,
   input logic                          rst_n,
   cv32e40p_rf_wport_arbiter_if.slave   bus
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   logic                  head_live, ready, accept, direct, drop, push, pop, out_we;
   logic [ADDR_WIDTH-1:0] head_addr, out_addr;
   logic [DATA_WIDTH-1:0] head_data, out_data;
   logic [CW-1:0]         cnt;

   assign ready  = int'(cnt) < BUF_DEPTH;
   assign accept = bus.wb_we_i && ready;
   assign pop    = !bus.alu_we_i && cnt != '0;
   assign direct = !bus.alu_we_i && cnt == '0 && accept;
   assign drop   = bus.alu_we_i && bus.wb_waddr_i == bus.alu_waddr_i;
   assign push   = accept && !direct && !drop;

   cv32e40p_rf_wbuf #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (BUF_DEPTH)
   ) u_wbuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_live(bus.wb_waddr_i != '0),
      .push_addr(bus.wb_waddr_i),
      .push_data(bus.wb_wdata_i),
      .pop      (pop),
      .kill     (bus.alu_we_i),
      .kill_addr(bus.alu_waddr_i),
      .head_live(head_live),
      .head_addr(head_addr),
      .head_data(head_data),
      .cnt      (cnt),
      .raddr_a  (bus.raddr_a_i),
      .raddr_b  (bus.raddr_b_i),
      .hit_a    (bus.fwd_hit_a_o),
      .hit_b    (bus.fwd_hit_b_o),
      .data_a   (bus.fwd_data_a_o),
      .data_b   (bus.fwd_data_b_o)
   );

   // priority mux: ALU, then buffer head, then direct LSU; x0 and killed writes never enable the port
   always_comb begin
      out_we   = bus.alu_we_i ? bus.alu_waddr_i != '0 : pop ? head_live : direct && bus.wb_waddr_i != '0;
      out_addr = bus.alu_we_i ? bus.alu_waddr_i : pop ? head_addr : bus.wb_waddr_i;
      out_data = bus.alu_we_i ? bus.alu_wdata_i : pop ? head_data : bus.wb_wdata_i;
   end

   assign bus.wb_ready_o = ready;
   assign bus.pend_cnt_o = cnt;
   assign bus.rf_we_o    = out_we;
   assign bus.rf_waddr_o = out_we ? out_addr : '0;
   assign bus.rf_wdata_o = out_we ? out_data : '0;
endmodule

// File: tb/tb_cv32e40p_rf_wport_arbiter.sv
// tb_cv32e40p_rf_wport_arbiter: directed and random stimulus against a queue-based reference model
module tb_cv32e40p_rf_wport_arbiter;
   import cv32e40p_pkg::*;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int D  = 2;

   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; int cyc;} wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cv32e40p_rf_wport_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(D)) bus ();

   cv32e40p_rf_wport_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(D)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   rf_wreq_t mq[$];
   wr_t      exp_q[$];
   wr_t      lsu_q[$];
   int       checks = 0;
   int       failures = 0;
   int       cyc = 0;
   bit       mon_en = 1'b0;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic logic [DW:0] model_fwd(input logic [AW-1:0] ra);
      for (int i = mq.size() - 1; i >= 0; i--)
         if (ra != '0 && mq[i].live && mq[i].waddr == ra) return {1'b1, mq[i].wdata};
      return '0;
   endfunction

   function automatic rf_wreq_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
      rf_wreq_t r;
      r.live  = a != '0;
      r.waddr = a;
      r.wdata = d;
      return r;
   endfunction

   function automatic wr_t ew(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t w;
      w.a = a; w.d = d; w.cyc = cyc;
      return w;
   endfunction

   // monitor: every enabled port write must be the next expected write in the same cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.rf_we_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=%0d/%h expected=none (cycle %0d)", bus.rf_waddr_o, bus.rf_wdata_o, cyc);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_cycle", 64'(cyc), 64'(e.cyc));
               chk("wr_addr", 64'(bus.rf_waddr_o), 64'(e.a));
               chk("wr_data", 64'(bus.rf_wdata_o), 64'(e.d));
            end
         end else begin
            chk("idle_port", {bus.rf_waddr_o, bus.rf_wdata_o}, 64'd0);
         end
      end
   end

   task automatic step(input bit awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      bit            we, acc;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [DW:0]   f;
      rf_wreq_t      h;
      we = lsu_q.size() > 0;
      wa = we ? lsu_q[0].a : AW'($urandom);
      wd = we ? lsu_q[0].d : $urandom;
      bus.alu_we_i    = awe;
      bus.alu_waddr_i = aa;
      bus.alu_wdata_i = ad;
      bus.wb_we_i     = we;
      bus.wb_waddr_i  = wa;
      bus.wb_wdata_i  = wd;
      bus.raddr_a_i   = ra;
      bus.raddr_b_i   = rb;
      #1;
      chk("wb_ready", 64'(bus.wb_ready_o), 64'(mq.size() < D));
      chk("pend_cnt", 64'(bus.pend_cnt_o), 64'(mq.size()));
      f = model_fwd(ra);
      chk("fwd_a", {bus.fwd_hit_a_o, bus.fwd_data_a_o}, 64'(f));
      f = model_fwd(rb);
      chk("fwd_b", {bus.fwd_hit_b_o, bus.fwd_data_b_o}, 64'(f));
      acc = we && mq.size() < D;
      if (awe) begin
         if (aa != '0) exp_q.push_back(ew(aa, ad));
         for (int i = 0; i < mq.size(); i++) if (mq[i].waddr == aa) mq[i].live = 1'b0;
         if (acc && wa != aa) mq.push_back(mk(wa, wd));
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (h.live) exp_q.push_back(ew(h.waddr, h.wdata));
         if (acc) mq.push_back(mk(wa, wd));
      end else if (acc && wa != '0) begin
         exp_q.push_back(ew(wa, wd));
      end
      if (acc) void'(lsu_q.pop_front());
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic lsu(input logic [AW-1:0] a, input logic [DW-1:0] d);
      lsu_q.push_back(ew(a, d));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
   endtask

   // reset cycle carries an x0 ALU write so the buffer is neither popped nor shown on the port
   task automatic mid_reset();
      rst_n = 1'b0;
      bus.alu_we_i = 1'b1; bus.alu_waddr_i = '0; bus.alu_wdata_i = '0; bus.wb_we_i = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      mq.delete();
      lsu_q.delete();
   endtask

   initial begin
      bus.alu_we_i = 1'b0; bus.alu_waddr_i = '0; bus.alu_wdata_i = '0;
      bus.wb_we_i = 1'b0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0;
      bus.raddr_a_i = 6'd5; bus.raddr_b_i = 6'd9;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_pend_cnt", 64'(bus.pend_cnt_o), 64'd0);
      chk("rst_wb_ready", 64'(bus.wb_ready_o), 64'd1);
      chk("rst_rf_port", {bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o}, 64'd0);
      chk("rst_fwd", {bus.fwd_hit_a_o, bus.fwd_hit_b_o, bus.fwd_data_a_o}, 64'd0);
      chk("rst_fwd_b", 64'(bus.fwd_data_b_o), 64'd0);
      mon_en = 1'b1;
      lsu(6'd5, 32'hA5); step(1'b0, '0, '0, '0, '0); idle(1);
      lsu(6'd7, 32'h22); step(1'b1, 6'd3, 32'h11, 6'd7, '0); idle(2);
      lsu(6'd10, 32'h1); lsu(6'd11, 32'h2); lsu(6'd12, 32'h3);
      for (int i = 0; i < 4; i++) step(1'b1, 6'(20 + i), 32'(100 + i), 6'd10, 6'd11);
      idle(4);
      lsu(6'd9, 32'h33); step(1'b1, 6'd1, 32'h5, 6'd9, '0);
      step(1'b1, 6'd9, 32'h44, 6'd9, '0);
      step(1'b1, 6'd2, 32'h6, 6'd9, 6'd9);
      idle(2);
      lsu(6'd9, 32'h55); step(1'b1, 6'd9, 32'h66, 6'd9, '0); idle(2);
      lsu(6'd4, 32'h1); step(1'b1, 6'd1, 32'h7, '0, 6'd4);
      lsu(6'd4, 32'h2); step(1'b1, 6'd2, 32'h8, '0, 6'd4);
      step(1'b1, 6'd3, 32'h9, 6'd4, 6'd4);
      step(1'b1, 6'd3, 32'h9, 6'd4, '0);
      idle(3);
      lsu(6'd13, 32'hD); lsu(6'd14, 32'hE);
      step(1'b1, 6'd1, 32'h1, '0, '0); step(1'b1, 6'd2, 32'h2, 6'd13, 6'd14);
      mid_reset();
      idle(3);
      lsu(6'd0, 32'hBAD); step(1'b0, '0, '0, '0, '0);
      lsu(6'd0, 32'hBAD); step(1'b1, 6'd8, 32'h80, '0, '0); idle(2);
      for (int i = 0; i < 400; i++) begin
         if (lsu_q.size() < 2 && $urandom_range(1, 0) == 1) lsu(AW'($urandom_range(7, 0)), $urandom);
         step($urandom_range(9, 0) < 6, AW'($urandom_range(7, 0)), $urandom, AW'($urandom_range(7, 0)), AW'($urandom_range(7, 0)));
      end
      for (int i = 0; i < 30 && (lsu_q.size() > 0 || mq.size() > 0); i++) idle(1);
      idle(1);
      chk("drain_lsu_empty", 64'(lsu_q.size()), 64'd0);
      chk("drain_model_empty", 64'(mq.size()), 64'd0);
      chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/cv32e40p_rf_wport_arbiter.md
# cv32e40p_rf_wport_arbiter

Shares the single register-file write port between the two EX-stage write sources: the ALU/CSR forwarding port (`regfile_alu_*`) and the LSU write-back port (`regfile_*_wb`). ALU writes always win. Colliding LSU writes are parked in a small ordered buffer that drains in ALU-idle cycles. The buffer also provides read-address lookup so ID can bypass pending load data. It sits between the EX stage outputs and the register file, and its `wb_ready_o` drives the EX stage's `wb_ready_i`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: register address width (GPR + FP space).
- `DATA_WIDTH`, default 32: write data width.
- `BUF_DEPTH`, default 2: LSU park-buffer entries, ≥1.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `alu_we_i`  in  1  ALU/CSR write request; no backpressure, always consumed in the same cycle.
- `alu_waddr_i`  in  ADDR_WIDTH  ALU write address.
- `alu_wdata_i`  in  DATA_WIDTH  ALU write data.
- `wb_we_i`  in  1  LSU write request.
- `wb_waddr_i`  in  ADDR_WIDTH  LSU write address.
- `wb_wdata_i`  in  DATA_WIDTH  LSU write data.
- `wb_ready_o`  out  1  LSU write accepted this cycle when high together with `wb_we_i`.
- `rf_we_o`  out  1  physical write enable.
- `rf_waddr_o`  out  ADDR_WIDTH  physical write address.
- `rf_wdata_o`  out  DATA_WIDTH  physical write data.
- `raddr_a_i`, `raddr_b_i`  in  ADDR_WIDTH  ID read addresses for the bypass lookup.
- `fwd_hit_a_o`, `fwd_hit_b_o`  out  1  a live buffered write matches the corresponding read address.
- `fwd_data_a_o`, `fwd_data_b_o`  out  DATA_WIDTH  matching data; 0 when no hit.
- `pend_cnt_o`  out  $clog2(BUF_DEPTH+1)  occupied entries, including killed entries.

## Operation
- The buffer is a FIFO. Each entry holds {live, waddr, wdata}. The FIFO keeps program order.
- **Source selection each cycle**, in priority order:
  1. If `alu_we_i`, the ALU write drives the port.
  2. Else, if the buffer is non-empty, pop the head and drive the port with `rf_we_o = head.live`.
  3. Else, if an LSU write is accepted, it bypasses the buffer and drives the port directly.
- **LSU acceptance:**
  - `wb_ready_o = (pend_cnt < BUF_DEPTH)`. It depends on state only; there is no combinational path from `wb_we_i`.
  - An accepted write that does not go to the port directly is enqueued live.
  - The LSU side holds its request until it is accepted.
- **Ordering and kill:**
  - An ALU write is always younger than any LSU write present in the same or earlier cycles.
  - On `alu_we_i`, every buffered entry with `waddr == alu_waddr_i` has `live` cleared.
  - A same-cycle accepted LSU write to `alu_waddr_i` is acknowledged and dropped, not enqueued.
- **x0:**
  - Any write with address 0 from either source is acknowledged but never asserts `rf_we_o`.
  - An LSU write to address 0 is enqueued non-live if it is not sent to the port directly.
  - Lookups of address 0 never hit.
- **Lookup:** a hit requires a live entry with a matching address. When several entries match, the youngest supplies the data.
- **Idle outputs:** when `rf_we_o=0`, `rf_waddr_o` and `rf_wdata_o` are 0.
- **Simultaneous pop and push:** allowed in the same cycle. The count is unchanged.
- **Push into a full buffer:** cannot occur, because `wb_ready_o=0`.

## Timing
- **Reset values:** `pend_cnt_o=0`, `wb_ready_o=1`, `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0`, all `fwd_hit_*=0`, all `fwd_data_*=0`.
- **Reset asserted mid-operation:** the buffer is discarded at that edge and the parked writes are lost. Issuing reset only at a pipeline flush is the system's responsibility.
- **ALU write latency:** 0 cycles (combinational to the port).
- **LSU write latency:**
  - 0 cycles when the buffer is empty and the ALU is idle.
  - Otherwise 1 + (ALU-busy cycles until the entry reaches the head and a free cycle occurs).
- **Starvation:** continuous ALU writes starve the buffer indefinitely. The fill limit is visible through `wb_ready_o`.
- **`wb_ready_o` update:** it reflects the count registered at the previous edge. A drain in cycle N raises `wb_ready_o` in cycle N+1.
- **Lookup timing:** combinational on the registered buffer state. Writes enqueued in the current cycle are not visible until the next cycle.

## Structure
- `cv32e40p_pkg` holds:
  - `typedef struct packed {logic live; logic [5:0] waddr; logic [31:0] wdata;} rf_wreq_t`
  - `localparam RF_WBUF_DEPTH = 2`
- Sub-module `cv32e40p_rf_wbuf` contains:
  - the FIFO storage, head/tail pointers and count;
  - the per-entry kill compare;
  - the youngest-match lookup.
- The top level holds only the priority mux and the acceptance logic.

## Test plan
- **LSU only, buffer empty:** `wb_we_i=1`, `wb_waddr_i=5`, `wb_wdata_i=0xA5` → same cycle `rf_we_o=1`, `rf_waddr_o=5`, `rf_wdata_o=0xA5`; `pend_cnt_o` stays 0.
- **Collision:** ALU writes (3, 0x11) while LSU writes (7, 0x22) in the same cycle → the port carries 3/0x11 and `pend_cnt_o=1`. Next idle cycle: port carries 7/0x22 and the count returns to 0.
- **Fill and backpressure:** ALU busy for 4 cycles, LSU presents 3 writes →
  - `wb_ready_o` falls after 2 accepts;
  - the third write is held;
  - the writes drain in order 1, 2, 3 once the ALU goes idle.
- **Kill:**
  - Buffer holds (9, 0x33); ALU writes (9, 0x44) → the entry is killed and the later pop shows `rf_we_o=0`.
  - `raddr_a_i=9` → `fwd_hit_a_o=0` after the kill.
  - A same-cycle LSU write (9, x) with ALU write (9, y) → only y is written.
- **Lookup youngest:** buffer holds (4, 0x1) then (4, 0x2) → `raddr_b_i=4` gives `fwd_hit_b_o=1`, `fwd_data_b_o=0x2`. `raddr_b_i=0` gives no hit.
- **Reset mid-operation:** with 2 entries parked, assert `rst_n=0` for one edge → `pend_cnt_o=0`, `wb_ready_o=1`, and no parked write ever appears on the port.
